// File: rtl/alu_fsm_if.sv
// Decoder/ALU/PC-mux signal bundle for the NZP condition-code tracker.
// The clock and reset stay as plain ports on the block.
interface alu_fsm_if #(
    parameter int STATE_W = 3
);
    logic               n_dec_in;
    logic               z_dec_in;
    logic               p_dec_in;
    logic               n_alu_in;
    logic               z_alu_in;
    logic               p_alu_in;
    logic               we_reg_in;
    logic               br_in;
    logic               pc_ctl_0_out;
    logic [STATE_W-1:0] state_out;

    modport master (
        output n_dec_in, z_dec_in, p_dec_in,
        output n_alu_in, z_alu_in, p_alu_in,
        output we_reg_in, br_in,
        input  pc_ctl_0_out, state_out
    );

    modport slave (
        input  n_dec_in, z_dec_in, p_dec_in,
        input  n_alu_in, z_alu_in, p_alu_in,
        input  we_reg_in, br_in,
        output pc_ctl_0_out, state_out
    );
endinterface

// File: rtl/alu_fsm.sv
// NZP condition-code tracker and branch resolver feeding PC-mux select bit 0.
// Optional define ALU_FSM_FWD_EN: branch compare sees the code being written this cycle.
module alu_fsm #(
    parameter int STATE_W = 3
) (
    input  logic      clka,
    input  logic      reset_in,
    alu_fsm_if.slave  bus
);
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'b000,
        ST_N    = 3'b100,
        ST_Z    = 3'b010,
        ST_P    = 3'b001
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_cmp;

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        w_next = r_state;
        if (bus.we_reg_in) begin
            if (bus.n_alu_in)      w_next = ST_N;
            else if (bus.z_alu_in) w_next = ST_Z;
            else if (bus.p_alu_in) w_next = ST_P;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clka) begin
        if (reset_in) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

`ifdef ALU_FSM_FWD_EN
    // A write and a branch test in the same cycle resolve on the new flags.
    assign w_cmp = bus.we_reg_in ? w_next : r_state;
`else
    assign w_cmp = r_state;
`endif

    assign bus.pc_ctl_0_out = bus.br_in & ((bus.n_dec_in & (w_cmp == ST_N)) |
                                           (bus.z_dec_in & (w_cmp == ST_Z)) |
                                           (bus.p_dec_in & (w_cmp == ST_P)));
    assign bus.state_out    = r_state;
endmodule

// File: tb/tb_alu_fsm.sv
// Self-checking bench for alu_fsm: directed steps, expected values queued at drive time.
module tb_alu_fsm;
    logic clka;
    logic reset_in;
    int   errors;
    int   checks;

`ifdef ALU_FSM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    alu_fsm_if #(.STATE_W(3)) bus ();

    alu_fsm #(.STATE_W(3)) dut (
        .clka     (clka),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    logic       exp_pc_q[$];
    logic [2:0] exp_st_q[$];
    logic [2:0] m_state;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_next(input logic [2:0] s, input logic we, input logic [2:0] alu);
        if (!we)        return s;
        else if (alu[2]) return 3'b100;
        else if (alu[1]) return 3'b010;
        else if (alu[0]) return 3'b001;
        return s;
    endfunction

    // One cycle: drive at negedge, check branch output before the edge, state after it.
    // alu/dec are {n,z,p}.
    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [2:0] alu, input logic br, input logic [2:0] dec);
        logic [2:0] nxt;
        logic [2:0] cmp;
        logic       pc;
        logic       pc_exp;
        logic [2:0] st_exp;
        @(negedge clka);
        reset_in      = rst;
        bus.we_reg_in = we;
        bus.n_alu_in  = alu[2];
        bus.z_alu_in  = alu[1];
        bus.p_alu_in  = alu[0];
        bus.br_in     = br;
        bus.n_dec_in  = dec[2];
        bus.z_dec_in  = dec[1];
        bus.p_dec_in  = dec[0];
        nxt = model_next(m_state, we, alu);
        cmp = (FWD && we) ? nxt : m_state;
        pc  = br & ((dec[2] & (cmp == 3'b100)) | (dec[1] & (cmp == 3'b010)) |
                    (dec[0] & (cmp == 3'b001)));
        exp_pc_q.push_back(pc);
        exp_st_q.push_back(rst ? 3'b000 : nxt);
        #1;
        pc_exp = exp_pc_q.pop_front();
        check({tag, ".pc"}, {2'b00, bus.pc_ctl_0_out}, {2'b00, pc_exp});
        @(posedge clka);
        #1;
        st_exp  = exp_st_q.pop_front();
        m_state = st_exp;
        check({tag, ".st"}, bus.state_out, st_exp);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        m_state = 3'b000;
        reset_in = 1'b1;
        bus.we_reg_in = 1'b0; bus.br_in = 1'b0;
        bus.n_alu_in = 1'b0; bus.z_alu_in = 1'b0; bus.p_alu_in = 1'b0;
        bus.n_dec_in = 1'b0; bus.z_dec_in = 1'b0; bus.p_dec_in = 1'b0;

        // Reset, then IDLE never branches
        step("rst",         1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
        check("rst_const", bus.state_out, 3'b000);
        step("rst_alldec",  1'b1, 1'b0, 3'b000, 1'b1, 3'b111);
        step("idle_alldec", 1'b0, 1'b0, 3'b000, 1'b1, 3'b111);

        // ALU flags ignored without a write
        for (int i = 0; i < 6; i++)
            step("nowrite", 1'b0, 1'b0, 3'b100 >> (i % 3), 1'b0, 3'b000);
        check("nowrite_const", bus.state_out, 3'b000);

        // Capture and hold
        step("cap_n",    1'b0, 1'b1, 3'b100, 1'b0, 3'b000);
        check("cap_n_const", bus.state_out, 3'b100);
        step("cap_z",    1'b0, 1'b1, 3'b010, 1'b0, 3'b000);
        check("cap_z_const", bus.state_out, 3'b010);
        step("cap_p",    1'b0, 1'b1, 3'b001, 1'b0, 3'b000);
        step("cap_none", 1'b0, 1'b1, 3'b000, 1'b0, 3'b000);
        check("hold_p_const", bus.state_out, 3'b001);

        // Branch taken in each state
        step("take_p",   1'b0, 1'b0, 3'b000, 1'b1, 3'b001);
        step("set_n",    1'b0, 1'b1, 3'b100, 1'b0, 3'b000);
        step("take_n",   1'b0, 1'b0, 3'b000, 1'b1, 3'b100);
        check("take_n_const", {2'b00, bus.pc_ctl_0_out}, 3'b001);
        step("set_z",    1'b0, 1'b1, 3'b010, 1'b0, 3'b000);
        step("take_z",   1'b0, 1'b0, 3'b000, 1'b1, 3'b010);

        // Not taken: no branch, mismatched mask
        step("nobr_z",   1'b0, 1'b0, 3'b000, 1'b0, 3'b010);
        step("set_n2",   1'b0, 1'b1, 3'b100, 1'b0, 3'b000);
        step("mism_n",   1'b0, 1'b0, 3'b000, 1'b1, 3'b011);
        check("mism_n_const", {2'b00, bus.pc_ctl_0_out}, 3'b000);

        // Priority N > Z > P, same-state transition
        step("prio_nzp", 1'b0, 1'b1, 3'b111, 1'b0, 3'b000);
        step("prio_zp",  1'b0, 1'b1, 3'b011, 1'b0, 3'b000);
        step("z_to_z",   1'b0, 1'b1, 3'b010, 1'b0, 3'b000);

        // Write and branch test in the same cycle
        step("set_p",    1'b0, 1'b1, 3'b001, 1'b0, 3'b000);
        step("fwd",      1'b0, 1'b1, 3'b100, 1'b1, 3'b100);
        check("fwd_const", bus.state_out, 3'b100);

        // Reset overrides a write
        step("rst_ovr",  1'b1, 1'b1, 3'b100, 1'b1, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
